// File: rtl/cmp_sweep_ctrl_if.sv
// ----------------------------------------------------------------------------
// cmp_sweep_ctrl_if
//   Bundles the signals between the comparator sweep sequencer and its
//   surroundings (buttons, comparator instance, LEDs, status).
//
//   start, pause          : level controls from the board
//   a_out, b_out          : 2-bit operands presented to the comparator
//   red_in/green_in/blue_in: comparator result (a>b / a==b / a<b)
//   led_r, led_g, led_b   : registered colour sampled from the comparator
//   idx                   : current vector index 0..15
//   busy, done            : sweep status
//   err_cnt, fail_map     : self-check results (zero when the check is disabled)
//
//   master : the sequencer side
//   slave  : the environment side (board / comparator / bench)
// ----------------------------------------------------------------------------
interface cmp_sweep_ctrl_if;
    logic        start;
    logic        pause;
    logic [1:0]  a_out;
    logic [1:0]  b_out;
    logic        red_in;
    logic        green_in;
    logic        blue_in;
    logic        led_r;
    logic        led_g;
    logic        led_b;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
    logic [4:0]  err_cnt;
    logic [15:0] fail_map;

    modport master (
        input  start, pause, red_in, green_in, blue_in,
        output a_out, b_out, led_r, led_g, led_b, idx, busy, done,
               err_cnt, fail_map
    );

    modport slave (
        output start, pause, red_in, green_in, blue_in,
        input  a_out, b_out, led_r, led_g, led_b, idx, busy, done,
               err_cnt, fail_map
    );
endinterface

// File: rtl/cmp_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// cmp_sweep_ctrl
//   Sequencer for a 2-bit magnitude comparator with RGB LED outputs. Steps the
//   operand pair through all 16 (a,b) combinations, lets the comparator settle,
//   samples its colour into the LED register and holds each vector for
//   DWELL_CYCLES clock cycles (pause freezes the dwell).
//
//   Optional feature macro: CMP_SELF_CHECK_EN
//     defined     : each sampled colour is compared against the one-hot
//                   expectation; mismatches set fail_map[idx] and bump err_cnt.
//     not defined : no checking; err_cnt and fail_map stay 0.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : synchronous active-low reset
//     bus    : cmp_sweep_ctrl_if.master (controls, operands, result, status)
// ----------------------------------------------------------------------------
module cmp_sweep_ctrl #(
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    cmp_sweep_ctrl_if.master  bus
);

    localparam int            CW       = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DWELL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     led_q, led_d;
    logic [4:0]     err_cnt_q, err_cnt_d;
    logic [15:0]    fail_map_q, fail_map_d;
`ifdef CMP_SELF_CHECK_EN
    logic [2:0]     exp_rgb;
`endif

    // Next-state and datapath update. Everything holds unless the current
    // state says otherwise; a start from IDLE or DONE always begins a fresh
    // sweep with cleared results.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        led_d      = led_q;
        err_cnt_d  = err_cnt_q;
        fail_map_d = fail_map_q;
`ifdef CMP_SELF_CHECK_EN
        exp_rgb    = {idx_q[3:2] > idx_q[1:0],
                      idx_q[3:2] == idx_q[1:0],
                      idx_q[3:2] < idx_q[1:0]};
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_SETTLE;
                    idx_d      = 4'd0;
                    err_cnt_d  = 5'd0;
                    fail_map_d = 16'd0;
                end
            end

            S_SETTLE: begin
                state_d = S_SAMPLE;
            end

            S_SAMPLE: begin
                led_d   = {bus.red_in, bus.green_in, bus.blue_in};
                cnt_d   = '0;
                state_d = S_DWELL;
`ifdef CMP_SELF_CHECK_EN
                // Any colour other than the exact one-hot answer is a failure,
                // including several LEDs lit at once or none at all.
                if ({bus.red_in, bus.green_in, bus.blue_in} != exp_rgb) begin
                    fail_map_d[idx_q] = 1'b1;
                    err_cnt_d         = err_cnt_q + 5'd1;
                end
`endif
            end

            S_DWELL: begin
                if (!bus.pause) begin
                    if (cnt_q == LAST_CNT) begin
                        if (idx_q == 4'd15) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_SETTLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset aborts any
    // sweep in progress and clears all visible results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            cnt_q      <= '0;
            led_q      <= 3'd0;
            err_cnt_q  <= 5'd0;
            fail_map_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
            err_cnt_q  <= err_cnt_d;
            fail_map_q <= fail_map_d;
        end
    end

    // Output mapping: operands are simply the two halves of the index.
    always_comb begin
        bus.a_out    = idx_q[3:2];
        bus.b_out    = idx_q[1:0];
        bus.idx      = idx_q;
        bus.led_r    = led_q[2];
        bus.led_g    = led_q[1];
        bus.led_b    = led_q[0];
        bus.busy     = (state_q == S_SETTLE) || (state_q == S_SAMPLE) ||
                       (state_q == S_DWELL);
        bus.done     = (state_q == S_DONE);
        bus.err_cnt  = err_cnt_q;
        bus.fail_map = fail_map_q;
    end

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cmp_sweep_ctrl
//   Bench for cmp_sweep_ctrl with DWELL_CYCLES=4. A behavioural comparator
//   (with injectable faults) answers the DUT's operands. For every sweep the
//   bench builds a per-cycle timeline of expected outputs from the sweep
//   rules (2 cycles per vector plus DWELL_CYCLES unpaused dwell cycles) and
//   compares the DUT against it every cycle.
// ----------------------------------------------------------------------------
module tb_cmp_sweep_ctrl;

    localparam int D    = 4;
    localparam int MAXC = 2048;

    logic clk;
    logic rst_n;

    cmp_sweep_ctrl_if bus ();

    cmp_sweep_ctrl #(.DWELL_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Fault injection for the behavioural comparator
    logic       red_stuck;
    logic [2:0] corrupt [16];
    logic [2:0] cmp_rgb;

    // Expected timeline, indexed by cycle number relative to the start cycle
    logic [9:0]  e_ctl [MAXC];
    logic [23:0] e_res [MAXC];
    logic        pz    [MAXC];
    logic [2:0]  led_prev;

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Correct comparator answer for vector v = {a,b}
    function automatic logic [2:0] ideal(input logic [3:0] v);
        return {v[3:2] > v[1:0], v[3:2] == v[1:0], v[3:2] < v[1:0]};
    endfunction

    // What the (possibly faulty) comparator shows for vector v
    function automatic logic [2:0] shown(input logic [3:0] v);
        logic [2:0] c;
        c = ideal(v) ^ corrupt[v];
        if (red_stuck) c[2] = 1'b0;
        return c;
    endfunction

    // Behavioural comparator driving the DUT inputs
    always_comb begin
        cmp_rgb = shown({bus.a_out, bus.b_out});
    end
    assign bus.red_in   = cmp_rgb[2];
    assign bus.green_in = cmp_rgb[1];
    assign bus.blue_in  = cmp_rgb[0];

    // Runs one full sweep from IDLE/DONE (called at a negedge).
    // pause_mode: 0 none, 1 random, 2 ten cycles in the middle of idx 5's dwell.
    task automatic run_sweep(input int pause_mode, input int start_pct,
                             output int done_cycle);
        int          t, cnt, done_at;
        logic [4:0]  run_err;
        logic [15:0] run_map;
        logic [2:0]  led_v;
        logic [9:0]  got_ctl;
        logic [23:0] got_res;

        for (int c = 0; c < MAXC; c++)
            pz[c] = (pause_mode == 1) ? ($urandom_range(99) < 30) : 1'b0;
        if (pause_mode == 2)
            for (int c = 34; c < 44; c++) pz[c] = 1'b1;

        // Build the expected timeline
        run_err = 5'd0;
        run_map = 16'd0;
        t = 1;
        for (int v = 0; v < 16; v++) begin
            led_v = (v == 0) ? led_prev : shown(4'(v - 1));
            for (int s = 0; s < 2; s++) begin
                e_ctl[t] = {4'(v), 4'(v), 1'b1, 1'b0};
                e_res[t] = {led_v, run_err, run_map};
                t++;
            end
`ifdef CMP_SELF_CHECK_EN
            if (shown(4'(v)) != ideal(4'(v))) begin
                run_err = run_err + 5'd1;
                run_map[v] = 1'b1;
            end
`endif
            cnt = 0;
            while (cnt < D && t < MAXC - 8) begin
                e_ctl[t] = {4'(v), 4'(v), 1'b1, 1'b0};
                e_res[t] = {shown(4'(v)), run_err, run_map};
                if (!pz[t]) cnt++;
                t++;
            end
        end
        done_at = t;
        for (int c = done_at; c < done_at + 4; c++) begin
            e_ctl[c] = {4'd15, 4'd15, 1'b0, 1'b1};
            e_res[c] = {shown(4'd15), run_err, run_map};
        end

        // Drive and check cycle by cycle
        done_cycle = -1;
        bus.start = 1'b1;
        bus.pause = pz[0];
        for (int k = 1; k < done_at + 4; k++) begin
            @(negedge clk);
            got_ctl = {bus.idx, bus.a_out, bus.b_out, bus.busy, bus.done};
            got_res = {bus.led_r, bus.led_g, bus.led_b, bus.err_cnt, bus.fail_map};
            checks++;
            if (got_ctl !== e_ctl[k]) begin
                errors++;
                $display("[TB] FAIL sweep_ctl cyc %0d: got idx/a/b/busy/done=%h want %h",
                         k, got_ctl, e_ctl[k]);
            end
            checks++;
            if (got_res !== e_res[k]) begin
                errors++;
                $display("[TB] FAIL sweep_res cyc %0d: got led/err/map=%h want %h",
                         k, got_res, e_res[k]);
            end
            if (bus.done === 1'b1 && done_cycle < 0) done_cycle = k;
            bus.start = (k < done_at) && ($urandom_range(99) < start_pct);
            bus.pause = pz[k];
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        led_prev  = shown(4'd15);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.pause = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.idx, bus.busy, bus.done, bus.led_r, bus.led_g, bus.led_b,
             bus.err_cnt, bus.fail_map, bus.a_out, bus.b_out} !== 35'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got idx=%h busy=%b done=%b led=%b%b%b err=%0d map=%h want all 0",
                     bus.idx, bus.busy, bus.done, bus.led_r, bus.led_g, bus.led_b,
                     bus.err_cnt, bus.fail_map);
        end
        rst_n     = 1'b1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.idx} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b done=%b idx=%h want 0 0 0",
                     bus.busy, bus.done, bus.idx);
        end
        led_prev = 3'd0;
    endtask

    task automatic test_basic_sweep();
        int dc;
        run_sweep(0, 0, dc);
        checks++;
        if (dc !== 16 * (D + 2) + 1) begin
            errors++;
            $display("[TB] FAIL done_latency: got %0d want %0d", dc, 16 * (D + 2) + 1);
        end
    endtask

    task automatic test_pause();
        int dc;
        run_sweep(2, 0, dc);
        checks++;
        if (dc !== 16 * (D + 2) + 1 + 10) begin
            errors++;
            $display("[TB] FAIL pause_latency: got %0d want %0d", dc, 16 * (D + 2) + 11);
        end
    endtask

    task automatic test_red_stuck();
        int          dc;
        logic [4:0]  want_err;
        logic [15:0] want_map;
        red_stuck = 1'b1;
        run_sweep(0, 0, dc);
`ifdef CMP_SELF_CHECK_EN
        want_err = 5'd6;
        want_map = 16'h7310;
`else
        want_err = 5'd0;
        want_map = 16'h0000;
`endif
        checks++;
        if (bus.err_cnt !== want_err || bus.fail_map !== want_map) begin
            errors++;
            $display("[TB] FAIL red_stuck: got err=%0d map=%h want err=%0d map=%h",
                     bus.err_cnt, bus.fail_map, want_err, want_map);
        end
        red_stuck = 1'b0;
    endtask

    task automatic test_random();
        int dc;
        for (int n = 0; n < 4; n++) begin
            for (int v = 0; v < 16; v++)
                corrupt[v] = ($urandom_range(3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            red_stuck = ($urandom_range(3) == 0);
            run_sweep(1, 20, dc);
        end
        red_stuck = 1'b0;
        for (int v = 0; v < 16; v++) corrupt[v] = 3'd0;
    endtask

    task automatic test_back_to_back();
        int dc;
        // Clean sweep straight from DONE: results from the faulty run must clear
        run_sweep(0, 0, dc);
        checks++;
        if (bus.err_cnt !== 5'd0 || bus.fail_map !== 16'd0) begin
            errors++;
            $display("[TB] FAIL restart_clear: got err=%0d map=%h want 0 0000",
                     bus.err_cnt, bus.fail_map);
        end
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1;
        bus.pause = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (57) @(negedge clk);
        checks++;
        if (bus.idx !== 4'd9 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_sweep_idx: got idx=%0d busy=%b want 9 1", bus.idx, bus.busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.idx, bus.busy, bus.done, bus.led_r, bus.led_g, bus.led_b,
             bus.err_cnt, bus.fail_map} !== 31'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got idx=%h busy=%b done=%b led=%b%b%b err=%0d map=%h want all 0",
                     bus.idx, bus.busy, bus.done, bus.led_r, bus.led_g, bus.led_b,
                     bus.err_cnt, bus.fail_map);
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({bus.idx, bus.busy, bus.done} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL stay_idle: got idx=%h busy=%b done=%b want 0 0 0",
                     bus.idx, bus.busy, bus.done);
        end
    endtask

    initial begin
        red_stuck = 1'b0;
        for (int v = 0; v < 16; v++) corrupt[v] = 3'd0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        led_prev  = 3'd0;
        @(negedge clk);
        test_reset();
        test_basic_sweep();
        test_pause();
        test_red_stuck();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
